// File: rtl/ysyx_22041461_pipe_stage_if.sv
// rtl/ysyx_22041461_pipe_stage_if.sv - valid/ready/data stream channel for the pipe stage
interface ysyx_22041461_pipe_stage_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ysyx_22041461_pipe_stage.sv
// rtl/ysyx_22041461_pipe_stage.sv - registered valid/ready pipe stage with optional skid register
// Define YSYX_22041461_PIPE_SKID_EN to add the skid register (registered in_ready, full throughput).
module ysyx_22041461_pipe_stage #(
  parameter int WIDTH      = 64,
  parameter int FLUSH_DATA = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  ysyx_22041461_pipe_stage_if.slave         in_s,
  ysyx_22041461_pipe_stage_if.master        out_s,
  output logic [1:0]                        count
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready;
  logic             accept;
  logic             deliver;

  assign accept  = in_s.valid & in_ready & ~flush;
  assign deliver = main_valid_q & out_s.ready;

  assign in_s.ready  = in_ready;
  assign out_s.valid = main_valid_q;
  assign out_s.data  = main_data_q;
  assign count       = count_q;

`ifdef YSYX_22041461_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  // in_ready depends only on flop state (and reset), never on out_ready.
  assign in_ready = rst & ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (FLUSH_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (!main_valid_q || deliver) begin
      // A full skid implies in_ready=0, so no accept can collide with the refill.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_s.data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_s.data;
    end
    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = rst & (out_s.ready | ~main_valid_q);

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      if (FLUSH_DATA != 0) main_data_d = '0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_s.data;
    end else if (deliver) begin
      main_valid_d = 1'b0;
    end
    count_d = {1'b0, main_valid_d};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      count_q      <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_pipe_stage.sv
// tb/tb_ysyx_22041461_pipe_stage.sv - directed and scoreboard bench for the pipe stage
module tb_ysyx_22041461_pipe_stage;
  localparam int WIDTH = 8;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] count;
  int         checks;
  int         failures;
  logic [WIDTH-1:0] q[$];

  ysyx_22041461_pipe_stage_if #(.WIDTH(WIDTH)) in_if ();
  ysyx_22041461_pipe_stage_if #(.WIDTH(WIDTH)) out_if ();

  ysyx_22041461_pipe_stage #(.WIDTH(WIDTH), .FLUSH_DATA(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .in_s  (in_if),
    .out_s (out_if),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = r;
    flush        = f;
  endtask

  initial begin
    logic exp_ready;
    logic v, r, f;
    logic [WIDTH-1:0] d;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_if.ready), 64'd0);
    check("rst_out_data", 64'(out_if.data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // streaming 1..4 at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
      step();
      check("stream_valid", 64'(out_if.valid), 64'd1);
      check("stream_data", 64'(out_if.data), 64'(i));
      check("stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("stream_drain_valid", 64'(out_if.valid), 64'd0);
    check("stream_drain_count", 64'(count), 64'd0);

`ifdef YSYX_22041461_PIPE_SKID_EN
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    step();
    check("bp_data_a", 64'(out_if.data), 64'h0A);
    check("bp_count1", 64'(count), 64'd1);
    drive(1'b1, 8'h0B, 1'b0, 1'b0);
    step();
    check("bp_hold_a", 64'(out_if.data), 64'h0A);
    check("bp_count2", 64'(count), 64'd2);
    check("bp_in_ready", 64'(in_if.ready), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1 check("bp_ready_no_comb", 64'(in_if.ready), 64'd0);
    step();
    check("bp_data_b", 64'(out_if.data), 64'h0B);
    check("bp_count_b", 64'(count), 64'd1);
    step();
    check("bp_count0", 64'(count), 64'd0);
    check("bp_valid0", 64'(out_if.valid), 64'd0);
    drive(1'b1, 8'h31, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    step();
    check("pre_flush_count", 64'(count), 64'd2);
`else
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    step();
    check("ns_data", 64'(out_if.data), 64'h11);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 check("ns_ready_lo", 64'(in_if.ready), 64'd0);
    out_if.ready = 1'b1;
    #1 check("ns_ready_hi", 64'(in_if.ready), 64'd1);
    out_if.ready = 1'b0;
    #1 check("ns_ready_lo2", 64'(in_if.ready), 64'd0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    step();
    check("ns_stall_data", 64'(out_if.data), 64'h11);
    check("ns_stall_count", 64'(count), 64'd1);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    step();
    check("ns_swap_data", 64'(out_if.data), 64'h22);
    check("ns_swap_valid", 64'(out_if.valid), 64'd1);
    check("ns_swap_count", 64'(count), 64'd1);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    step();
    check("pre_flush_count", 64'(count), 64'd1);
`endif

    // flush with beats held and 0xC offered
    drive(1'b1, 8'h0C, 1'b1, 1'b1);
    step();
    check("flush_valid", 64'(out_if.valid), 64'd0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_data_zero", 64'(out_if.data), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("flush_no_c", 64'(out_if.valid), 64'd0);

    // async reset while one beat held
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    step();
    check("ar_count1", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 64'(out_if.valid), 64'd0);
    check("ar_in_ready", 64'(in_if.ready), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    step();
    check("ar_first_valid", 64'(out_if.valid), 64'd1);
    check("ar_first_data", 64'(out_if.data), 64'h05);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("ar_drain", 64'(out_if.valid), 64'd0);

    // random traffic against a queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      check("rnd_valid", 64'(out_if.valid), 64'(q.size() != 0));
      check("rnd_count", 64'(count), 64'(q.size()));
      if (q.size() != 0) check("rnd_data", 64'(out_if.data), 64'(q[0]));
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 2) != 0);
      f = 1'($urandom_range(0, 49) == 0);
      d = WIDTH'($urandom_range(0, 255));
      drive(v, d, r, f);
`ifdef YSYX_22041461_PIPE_SKID_EN
      exp_ready = (q.size() < 2);
`else
      exp_ready = r | (q.size() == 0);
`endif
      #1 check("rnd_in_ready", 64'(in_if.ready), 64'(exp_ready));
      if (f) begin
        q.delete();
      end else begin
        if (q.size() != 0 && r) void'(q.pop_front());
        if (v && exp_ready) q.push_back(d);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
